// File: rtl/mul8x8_ha_pkg.sv
// Shared widths and array type for the HA-array final accumulation stage.
package mul8x8_ha_pkg;

  localparam int HA_T_W = 9;
  localparam int HA_B_W = 7;
  localparam int ROW_W  = 10;
  localparam int PAIR_W = 12;
  localparam int PROD_W = 16;

  typedef struct packed {
    logic [HA_T_W-1:0] t;
    logic [HA_B_W-1:0] b;
  } ha_array_t;

  // b bits sit one position above the matching t bits.
  function automatic logic [ROW_W-1:0] row_sum(input ha_array_t a);
    return ROW_W'(a.t) + (ROW_W'(a.b) << 1);
  endfunction

endpackage

// File: rtl/ha_row_pair_add.sv
// Combines two adjacent HA rows; the upper row carries two extra bits of weight.
module ha_row_pair_add
  import mul8x8_ha_pkg::*;
(
  input  logic [ROW_W-1:0]  row_lo_i,
  input  logic [ROW_W-1:0]  row_hi_i,
  output logic [PAIR_W-1:0] pair_o
);

  assign pair_o = PAIR_W'(row_lo_i) + (PAIR_W'(row_hi_i) << 2);

endmodule

// File: rtl/unsigned_mul_8x8_ha_array_accum.sv
// Exact reduction of four HA row arrays to a 16b product behind a global-stall pipeline.
module unsigned_mul_8x8_ha_array_accum
  import mul8x8_ha_pkg::*;
#(
  parameter bit PIPE_MID = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HA_T_W-1:0] ha_t0,
  input  logic [HA_T_W-1:0] ha_t1,
  input  logic [HA_T_W-1:0] ha_t2,
  input  logic [HA_T_W-1:0] ha_t3,
  input  logic [HA_B_W-1:0] ha_b0,
  input  logic [HA_B_W-1:0] ha_b1,
  input  logic [HA_B_W-1:0] ha_b2,
  input  logic [HA_B_W-1:0] ha_b3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);

  logic                    advance;
  logic                    vld_p0_q;
  ha_array_t [3:0]         arr_p0_q;
  logic [ROW_W-1:0]        row_p0 [4];
  logic [PAIR_W-1:0]       pair_a_p0, pair_b_p0;
  logic                    vld_mid;
  logic [PAIR_W-1:0]       pair_a_mid, pair_b_mid;
  logic [PROD_W-1:0]       prod_p2_d;
  logic                    vld_p2_q;
  logic [PROD_W-1:0]       prod_p2_q;

  // Whole pipe moves together; only a held output can stall it.
  assign advance   = !vld_p2_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p2_q;
  assign product   = prod_p2_q;

  // Stage p0: input capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      arr_p0_q <= '0;
    end else if (advance) begin
      vld_p0_q    <= in_valid;
      arr_p0_q[0] <= {ha_t0, ha_b0};
      arr_p0_q[1] <= {ha_t1, ha_b1};
      arr_p0_q[2] <= {ha_t2, ha_b2};
      arr_p0_q[3] <= {ha_t3, ha_b3};
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) row_p0[k] = row_sum(arr_p0_q[k]);
  end

  ha_row_pair_add u_pair_a (
    .row_lo_i (row_p0[0]),
    .row_hi_i (row_p0[1]),
    .pair_o   (pair_a_p0)
  );

  ha_row_pair_add u_pair_b (
    .row_lo_i (row_p0[2]),
    .row_hi_i (row_p0[3]),
    .pair_o   (pair_b_p0)
  );

  // Stage p1: optional pair-sum register
  if (PIPE_MID) begin : g_mid
    logic              vld_p1_q;
    logic [PAIR_W-1:0] pair_a_p1_q, pair_b_p1_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p1_q    <= 1'b0;
        pair_a_p1_q <= '0;
        pair_b_p1_q <= '0;
      end else if (advance) begin
        vld_p1_q    <= vld_p0_q;
        pair_a_p1_q <= pair_a_p0;
        pair_b_p1_q <= pair_b_p0;
      end
    end

    assign vld_mid    = vld_p1_q;
    assign pair_a_mid = pair_a_p1_q;
    assign pair_b_mid = pair_b_p1_q;
  end else begin : g_nomid
    assign vld_mid    = vld_p0_q;
    assign pair_a_mid = pair_a_p0;
    assign pair_b_mid = pair_b_p0;
  end

  // Max 3825 + 3825*16 = 65025 fits 16b, so no saturation is needed.
  assign prod_p2_d = PROD_W'(pair_a_mid) + (PROD_W'(pair_b_mid) << 4);

  // Stage p2: product register, held across bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      prod_p2_q <= '0;
    end else if (advance) begin
      vld_p2_q <= vld_mid;
      if (vld_mid) prod_p2_q <= prod_p2_d;
    end
  end

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_accum.sv
// Randomized and directed bench for the HA-array accumulation stage.
module tb_unsigned_mul_8x8_ha_array_accum;

  localparam bit PIPE_MID = 1'b1;
  localparam int LAT      = PIPE_MID ? 3 : 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [8:0]  ha_t0, ha_t1, ha_t2, ha_t3;
  logic [6:0]  ha_b0, ha_b1, ha_b2, ha_b3;
  logic [15:0] product;

  unsigned_mul_8x8_ha_array_accum #(.PIPE_MID(PIPE_MID)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ha_t0(ha_t0), .ha_t1(ha_t1), .ha_t2(ha_t2), .ha_t3(ha_t3),
    .ha_b0(ha_b0), .ha_b1(ha_b1), .ha_b2(ha_b2), .ha_b3(ha_b3),
    .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, n_del = 0;
  int          acc_cyc = -1, first_out_cyc = -1;
  int          stall_from = -1000, stall_len = 0;
  bit          accepted, stall_prev;
  logic [15:0] prev_prod;
  logic [8:0]  tv [4];
  logic [6:0]  bv [4];
  int          exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every array bit contributes its own power-of-two weight.
  function automatic int ref_prod();
    int s = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) if (tv[k][i]) s += 1 << (2*k + i);
      for (int i = 0; i < 7; i++) if (bv[k][i]) s += 1 << (2*k + i + 1);
    end
    return s;
  endfunction

  task automatic apply_arrays();
    ha_t0 = tv[0]; ha_t1 = tv[1]; ha_t2 = tv[2]; ha_t3 = tv[3];
    ha_b0 = bv[0]; ha_b1 = bv[1]; ha_b2 = bv[2]; ha_b3 = bv[3];
  endtask

  task automatic clear_arrays();
    for (int k = 0; k < 4; k++) begin tv[k] = '0; bv[k] = '0; end
  endtask

  task automatic cycle();
    out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
    #1;
    accepted = 1'b0;
    chk("in_ready_rule", in_ready, !out_valid || out_ready);
    if (stall_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_product", product, prev_prod);
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_prod());
      accepted = 1'b1;
      acc_cyc  = cyc;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("product", product, exp_q.pop_front());
      n_del++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end
    stall_prev = out_valid && !out_ready;
    prev_prod  = product;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send();
    int tries = 0;
    apply_arrays();
    in_valid = 1'b1;
    do begin
      cycle();
      tries++;
    end while (!accepted && tries < 30);
    if (!accepted) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 40) begin cycle(); n++; end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic rand_arrays();
    for (int k = 0; k < 4; k++) begin
      tv[k] = 9'($urandom_range(0, 511));
      bv[k] = 7'($urandom_range(0, 127));
    end
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    clear_arrays(); apply_arrays();
    stall_prev = 1'b0; prev_prod = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // all zero, latency
    clear_arrays(); first_out_cyc = -1;
    send(); drain();
    chk("latency", first_out_cyc - acc_cyc, LAT);
    chk("zero_product", product, 0);

    // single-bit weights
    clear_arrays(); tv[0] = 9'h1FF; send(); drain(); chk("t0_max", product, 511);
    clear_arrays(); tv[3] = 9'h001; send(); drain(); chk("t3_lsb", product, 64);
    clear_arrays(); bv[3] = 7'h40;  send(); drain(); chk("b3_msb", product, 8192);
    clear_arrays(); bv[0] = 7'h01;  send(); drain(); chk("b0_lsb", product, 2);

    // upper bound
    for (int k = 0; k < 4; k++) begin tv[k] = 9'h1FF; bv[k] = 7'h7F; end
    send(); drain(); chk("max_bound", product, 16'hFE01);

    // back-to-back random stream
    base = n_del;
    for (int j = 0; j < 8; j++) begin
      rand_arrays(); apply_arrays(); in_valid = 1'b1;
      cycle();
      chk("b2b_accept", accepted, 1);
    end
    in_valid = 1'b0;
    repeat (LAT) cycle();
    chk("b2b_count", n_del - base, 8);
    drain();

    // backpressure mid-stream
    base = n_del;
    stall_from = cyc + 4; stall_len = 4;
    for (int j = 0; j < 5; j++) begin rand_arrays(); send(); end
    drain();
    chk("bp_count", n_del - base, 5);
    stall_from = -1000; stall_len = 0;

    // reset with two items in flight
    chk("pre_rst_product_nonzero", product != 0, 1);
    rand_arrays(); apply_arrays(); in_valid = 1'b1; cycle();
    rand_arrays(); apply_arrays(); cycle();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_product", product, 0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);
    base = n_del;
    repeat (6) cycle();
    chk("no_stale_items", n_del - base, 0);
    chk("post_rst_product", product, 0);

    // pipe still works after reset
    rand_arrays(); send(); drain();
    chk("post_rst_delivery", n_del - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
